button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_CYCLES, 20'd1_000_000, stable-sample count that confirms a press or release (10 ms at 100 MHz).
REQ-002 Parameters SHALL include LONG_CYCLES, 28'd100_000_000, hold count from confirmed press to long-press event (1 s); used only under LONG_PRESS_EN.
REQ-003 Clk_in  input  1  the single clock; every flop SHALL use its rising edge.
REQ-004 Rst_n_in  input  1  reset, asynchronous assert and active-low.
REQ-005 Button_in  input  1  raw, bouncing, asynchronous pushbutton level; 1 means pressed.
REQ-006 Level_out  output  1  debounced button level.
REQ-007 Press_out  output  1  single-cycle pulse on each confirmed press; drives the downstream toggle stage's clock or enable.
REQ-008 Release_out  output  1  single-cycle pulse on each confirmed release.
REQ-009 Long_out  output  1  single-cycle long-press pulse; present only under LONG_PRESS_EN.

Function
REQ-010 Button_in SHALL pass through a two-flop synchronizer; the FSM SHALL see only the synchronized value s.
REQ-011 The FSM SHALL have four states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-012 IDLE: s=1 -> PRESS_WAIT, counter cleared; s=0 -> stay.
REQ-013 PRESS_WAIT: s=0 -> IDLE, counter cleared (bounce rejected); s=1 -> counter+1; when counter reaches DEBOUNCE_CYCLES-1 with s=1 -> HELD.
REQ-014 HELD: s=0 -> REL_WAIT, counter cleared; s=1 -> stay.
REQ-015 REL_WAIT: s=1 -> HELD, counter cleared; s=0 -> counter+1; when counter reaches DEBOUNCE_CYCLES-1 with s=0 -> IDLE.
REQ-016 Press_out SHALL be registered and high for exactly the one cycle after the PRESS_WAIT->HELD transition.
REQ-017 Release_out SHALL be registered and high for exactly the one cycle after the REL_WAIT->IDLE transition.
REQ-018 Level_out SHALL be 1 in HELD and REL_WAIT and 0 otherwise, registered.
REQ-019 Latency from a clean Button_in edge to the pulse SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, exactly.
REQ-020 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES) bits and SHALL never wrap: it SHALL saturate and clear on every state change.
REQ-021 Press_out and Release_out SHALL never be high in the same cycle; at most one pulse per FSM transition.
REQ-022 With DEBOUNCE_CYCLES=1, a stable sample SHALL confirm the press or release in one cycle; no zero-length case exists.

Reset
REQ-023 Asserting Rst_n_in=0 SHALL force IDLE, clear both counters and the synchronizer, and drive every output to 0, independent of Clk_in.
REQ-024 Reset asserted mid-press SHALL emit no pulse; after deassertion a held button SHALL be re-debounced from IDLE and produce one Press_out.

Configuration
REQ-025 With macro BUTTON_LONG_PRESS_EN defined, a second counter SHALL run in HELD and REL_WAIT, clearing on entry to HELD from PRESS_WAIT.
REQ-026 Under BUTTON_LONG_PRESS_EN, Long_out SHALL pulse one cycle when that counter reaches LONG_CYCLES-1; it SHALL fire at most once per press, with the counter saturating.
REQ-027 Without BUTTON_LONG_PRESS_EN, port Long_out, its counter and LONG_CYCLES SHALL be absent from the build.

Structure
REQ-028 Package button_pkg SHALL hold the state enum (2-bit: IDLE=0, PRESS_WAIT=1, HELD=2, REL_WAIT=3) and the default DEBOUNCE_CYCLES and LONG_CYCLES constants.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff (1-bit, async active-low reset to 0).

Verification
REQ-030 Scenario: DEBOUNCE_CYCLES=8; Button_in 0->1 held 20 cycles -> one Press_out exactly 11 cycles after the edge, and Level_out=1.
REQ-031 Scenario: 5 glitches, each 3 cycles high and 2 low, then low -> no Press_out, Level_out stays 0, state returns to IDLE.
REQ-032 Scenario: press confirmed, then release with 4-cycle bounce then stable 0 -> one Release_out 11 cycles after the last bounce; no extra Press_out.
REQ-033 Scenario: Rst_n_in pulled low at cycle 5 of PRESS_WAIT with button held -> outputs 0 at once; after release of reset, one Press_out 11 cycles later.
REQ-034 Scenario: BUTTON_LONG_PRESS_EN with LONG_CYCLES=50; hold 120 cycles -> one Long_out 50 cycles after Press_out, no second Long_out.
REQ-035 Scenario: 4 clean presses feeding the downstream toggle stage -> 4 Press_out pulses, toggle output sequence 1,0,1,0.

Source files
------------

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and default constants for the pushbutton debouncer.
//   state_t              : debouncer FSM state encoding (2 bits)
//   DEF_DEBOUNCE_CYCLES  : default stable-sample count (10 ms at 100 MHz)
//   DEF_LONG_CYCLES      : default long-press hold count (1 s at 100 MHz),
//                          present only when BUTTON_LONG_PRESS_EN is defined
//   cnt_width()          : counter width able to hold values 0..n-1, minimum 1
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    localparam logic [19:0] DEF_DEBOUNCE_CYCLES = 20'd1_000_000;

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [27:0] DEF_LONG_CYCLES = 28'd100_000_000;
`endif

    // $clog2(1) is 0; a counter still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
//   i_clk   : destination clock (rising edge)
//   i_rst_n : asynchronous active-low reset, clears both flops to 0
//   i_d     : asynchronous input level
//   o_q     : synchronized level, two clocks of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Debounces a raw pushbutton level and emits press/release pulses.
// Optional long-press detection is built only when the macro
// BUTTON_LONG_PRESS_EN is defined.
//   Clk_in      : single clock, rising edge
//   Rst_n_in    : asynchronous active-low reset
//   Button_in   : raw asynchronous button level, 1 = pressed
//   Level_out   : debounced level (1 in HELD / REL_WAIT)
//   Press_out   : one-cycle pulse after each confirmed press
//   Release_out : one-cycle pulse after each confirmed release
//   Long_out    : one-cycle pulse LONG_CYCLES after a confirmed press
//                 (BUTTON_LONG_PRESS_EN only)
// Edge-to-pulse latency is 2 (sync) + DEBOUNCE_CYCLES + 1 clocks.
// -----------------------------------------------------------------------------
module button_debouncer
    import button_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BUTTON_LONG_PRESS_EN
  , parameter logic [27:0] LONG_CYCLES     = DEF_LONG_CYCLES
`endif
) (
    input  logic Clk_in,
    input  logic Rst_n_in,
    input  logic Button_in,
    output logic Level_out,
    output logic Press_out,
    output logic Release_out
`ifdef BUTTON_LONG_PRESS_EN
  , output logic Long_out
`endif
);

    localparam int unsigned    DW      = cnt_width(32'(DEBOUNCE_CYCLES));
    localparam logic [DW-1:0]  DC_LAST = DW'(DEBOUNCE_CYCLES - 20'd1);

`ifdef BUTTON_LONG_PRESS_EN
    // Counter holds 0..LONG_CYCLES; parking at LONG_CYCLES keeps the pulse
    // to one per press.
    localparam int unsigned    LW      = cnt_width(32'(LONG_CYCLES) + 32'd1);
    localparam logic [LW-1:0]  LC_LAST = LW'(LONG_CYCLES - 28'd1);
    localparam logic [LW-1:0]  LC_SAT  = LW'(LONG_CYCLES);

    logic [LW-1:0] r_lcnt;
    logic          r_long;
`endif

    logic          w_sync;
    state_t        r_state;
    logic [DW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    sync_2ff u_sync (
        .i_clk   (Clk_in),
        .i_rst_n (Rst_n_in),
        .i_d     (Button_in),
        .o_q     (w_sync)
    );

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
            r_lcnt    <= '0;
            r_long    <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_sync) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DC_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
                        r_lcnt  <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_sync) begin
                        r_state <= REL_WAIT;
                        r_cnt   <= '0;
                    end
                end
                REL_WAIT: begin
                    if (w_sync) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DC_LAST) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

`ifdef BUTTON_LONG_PRESS_EN
            // Hold time accumulates through release bounces (REL_WAIT).
            r_long <= 1'b0;
            if (r_state == HELD || r_state == REL_WAIT) begin
                if (r_lcnt != LC_SAT) begin
                    r_lcnt <= r_lcnt + 1'b1;
                end
                if (r_lcnt == LC_LAST) begin
                    r_long <= 1'b1;
                end
            end
`endif
        end
    end

    assign Level_out   = r_level;
    assign Press_out   = r_press;
    assign Release_out = r_release;
`ifdef BUTTON_LONG_PRESS_EN
    assign Long_out    = r_long;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 8
// (and LONG_CYCLES = 50 when BUTTON_LONG_PRESS_EN is defined).
// The reference model treats the debouncer as: the level flips once the
// button, seen two clocks late, has disagreed with the level for
// DEBOUNCE_CYCLES+1 consecutive clocks; a long press fires LONG_CYCLES
// clocks after a press while the level stays high.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int D = 8;
    localparam int L = 50;

    logic Clk_in;
    logic Rst_n_in;
    logic Button_in;
    logic Level_out;
    logic Press_out;
    logic Release_out;
`ifdef BUTTON_LONG_PRESS_EN
    logic Long_out;
`endif

    button_debouncer #(
        .DEBOUNCE_CYCLES (20'd8)
`ifdef BUTTON_LONG_PRESS_EN
      , .LONG_CYCLES     (28'd50)
`endif
    ) dut (
        .Clk_in      (Clk_in),
        .Rst_n_in    (Rst_n_in),
        .Button_in   (Button_in),
        .Level_out   (Level_out),
        .Press_out   (Press_out),
        .Release_out (Release_out)
`ifdef BUTTON_LONG_PRESS_EN
      , .Long_out    (Long_out)
`endif
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // reference model state
    logic raw_hist [2];          // raw samples: [0] latest, [1] one clock older
    logic m_level, m_press, m_rel, m_long;
    int   run;                   // consecutive samples disagreeing with m_level
    int   since;                 // clocks held since the last press

    // observed event bookkeeping
    int   press_cnt, rel_cnt, long_cnt;
    int   last_press_cyc, last_rel_cyc, last_long_cyc;
    logic tgl;                   // downstream toggle stage driven by Press_out

    typedef struct {
        logic b;
        int   len;
        int   exp_press;
        int   exp_rel;
        logic exp_level;
    } seg_t;

    seg_t vec [11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        raw_hist[0] = 1'b0;
        raw_hist[1] = 1'b0;
        m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        run   = 0;
        since = L + 1;
    endtask

    task automatic model_step();
        logic s, lvl_before;
        if (!Rst_n_in) begin
            model_reset();
        end else begin
            s           = raw_hist[1];
            raw_hist[1] = raw_hist[0];
            raw_hist[0] = Button_in;
            lvl_before  = m_level;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
            run = (s != m_level) ? run + 1 : 0;
            if (run == D + 1) begin
                m_level = ~m_level;
                run     = 0;
                if (m_level) begin
                    m_press = 1'b1;
                    since   = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end
            if (lvl_before) begin
                if (since <= L) since++;
                if (since == L) m_long = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("level",   int'(Level_out),   int'(m_level));
        check("press",   int'(Press_out),   int'(m_press));
        check("release", int'(Release_out), int'(m_rel));
`ifdef BUTTON_LONG_PRESS_EN
        check("long",    int'(Long_out),    int'(m_long));
`endif
    endtask

    task automatic tick();
        @(posedge Clk_in);
        cyc++;
        model_step();
        @(negedge Clk_in);
        compare_outputs();
        if (Press_out === 1'b1) begin
            press_cnt++; last_press_cyc = cyc; tgl = ~tgl;
        end
        if (Release_out === 1'b1) begin
            rel_cnt++; last_rel_cyc = cyc;
        end
`ifdef BUTTON_LONG_PRESS_EN
        if (Long_out === 1'b1) begin
            long_cnt++; last_long_cyc = cyc;
        end
`endif
    endtask

    task automatic run_level(input logic b, input int n);
        Button_in = b;
        for (int i = 0; i < n; i++) tick();
    endtask

    // asynchronous reset assertion partway between edges
    task automatic async_reset(input int dly);
        #(dly);
        Rst_n_in = 1'b0;
        model_reset();
        #1;
        compare_outputs();
    endtask

    initial begin
        int   p0, r0, l0, t0;
        logic exp_tgl [4];

        // hand-derived segment table (D = 8: 9 stable clocks confirm a change)
        vec[0]  = '{1'b1, 20, 1, 0, 1'b1};
        vec[1]  = '{1'b0, 20, 0, 1, 1'b0};
        vec[2]  = '{1'b1,  8, 0, 0, 1'b0};  // longest rejected pulse
        vec[3]  = '{1'b0, 20, 0, 0, 1'b0};
        vec[4]  = '{1'b1,  9, 0, 0, 1'b0};  // shortest accepted, confirms late
        vec[5]  = '{1'b0, 20, 1, 1, 1'b0};
        vec[6]  = '{1'b1, 30, 1, 0, 1'b1};
        vec[7]  = '{1'b0,  4, 0, 0, 1'b1};  // short release dip rejected
        vec[8]  = '{1'b1, 20, 0, 0, 1'b1};
        vec[9]  = '{1'b0, 20, 0, 1, 1'b0};
        vec[10] = '{1'b0,  5, 0, 0, 1'b0};

        press_cnt = 0; rel_cnt = 0; long_cnt = 0;
        last_press_cyc = 0; last_rel_cyc = 0; last_long_cyc = 0;
        tgl = 1'b0;

        Rst_n_in  = 1'b0;
        Button_in = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        check("reset_level", int'(Level_out), 0);
        Rst_n_in = 1'b1;
        run_level(1'b0, 5);

        // clean press: pulse exactly 2 + D + 1 clocks after the edge
        p0 = press_cnt; t0 = cyc;
        run_level(1'b1, 20);
        check("press_count_clean", press_cnt - p0, 1);
        check("press_latency", last_press_cyc - t0, 11);
        check("level_held", int'(Level_out), 1);
        run_level(1'b0, 20);

        // table-driven segments
        for (int i = 0; i < 11; i++) begin
            p0 = press_cnt; r0 = rel_cnt;
            run_level(vec[i].b, vec[i].len);
            check($sformatf("vec%0d_press", i), press_cnt - p0, vec[i].exp_press);
            check($sformatf("vec%0d_release", i), rel_cnt - r0, vec[i].exp_rel);
            check($sformatf("vec%0d_level", i), int'(Level_out), int'(vec[i].exp_level));
        end

        // glitch train is rejected, then a clean press still takes full latency
        p0 = press_cnt;
        for (int i = 0; i < 5; i++) begin
            run_level(1'b1, 3);
            run_level(1'b0, 2);
        end
        run_level(1'b0, 20);
        check("glitch_press", press_cnt - p0, 0);
        check("glitch_level", int'(Level_out), 0);
        t0 = cyc;
        run_level(1'b1, 20);
        check("post_glitch_latency", last_press_cyc - t0, 11);

        // release with bounce
        p0 = press_cnt; r0 = rel_cnt;
        run_level(1'b0, 1); run_level(1'b1, 1);
        run_level(1'b0, 1); run_level(1'b1, 1);
        t0 = cyc;
        run_level(1'b0, 20);
        check("bounce_release_count", rel_cnt - r0, 1);
        check("bounce_release_latency", last_rel_cyc - t0, 11);
        check("bounce_no_press", press_cnt - p0, 0);

        // reset during PRESS_WAIT with the button held
        p0 = press_cnt;
        run_level(1'b1, 7);
        async_reset(2);
        check("rst_mid_press_level", int'(Level_out), 0);
        check("rst_mid_press_pulse", int'(Press_out), 0);
        for (int i = 0; i < 3; i++) tick();
        Rst_n_in = 1'b1;
        t0 = cyc;
        run_level(1'b1, 20);
        check("rst_repress_count", press_cnt - p0, 1);
        check("rst_repress_latency", last_press_cyc - t0, 11);
        // reset while held drops the level without waiting for a clock
        async_reset(2);
        check("rst_held_level", int'(Level_out), 0);
        tick(); tick();
        Rst_n_in = 1'b1;
        run_level(1'b0, 20);

`ifdef BUTTON_LONG_PRESS_EN
        l0 = long_cnt;
        run_level(1'b1, 120);
        check("long_count", long_cnt - l0, 1);
        check("long_delay", last_long_cyc - last_press_cyc, 50);
        run_level(1'b0, 20);
`else
        l0 = 0;
`endif

        // four clean presses into the toggle stage
        exp_tgl[0] = 1'b1; exp_tgl[1] = 1'b0; exp_tgl[2] = 1'b1; exp_tgl[3] = 1'b0;
        tgl = 1'b0;
        p0 = press_cnt;
        for (int i = 0; i < 4; i++) begin
            run_level(1'b1, 15);
            check($sformatf("toggle%0d", i), int'(tgl), int'(exp_tgl[i]));
            run_level(1'b0, 15);
        end
        check("toggle_presses", press_cnt - p0, 4);

        // random stimulus against the model, with occasional async resets
        for (int i = 0; i < 200; i++) begin
            run_level(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
            if ($urandom_range(0, 39) == 0) begin
                async_reset(int'($urandom_range(1, 3)));
                tick();
                Rst_n_in = 1'b1;
            end
        end
        run_level(1'b0, 20);
        check("final_level", int'(Level_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
